// File: rtl/tlc_pkg.sv
// Shared encodings for the two-approach traffic-light phase sequencer:
// FSM state codes, one-hot light patterns and queue-counter commands.
package tlc_pkg;

    localparam logic [2:0] S_RED_TO_NS = 3'd0;
    localparam logic [2:0] S_NS_GREEN  = 3'd1;
    localparam logic [2:0] S_NS_YELLOW = 3'd2;
    localparam logic [2:0] S_RED_TO_EW = 3'd3;
    localparam logic [2:0] S_EW_GREEN  = 3'd4;
    localparam logic [2:0] S_EW_YELLOW = 3'd5;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    localparam logic [1:0] W_HOLD = 2'b00;
    localparam logic [1:0] W_UP   = 2'b01;
    localparam logic [1:0] W_DOWN = 2'b10;

    // Light pattern for one approach in a given state; anything not owned
    // by that approach is red, so the two approaches can never both be lit.
    function automatic logic [2:0] light_of(input logic [2:0] st, input logic is_ns);
        logic [2:0] l;
        l = L_RED;
        case (st)
            S_NS_GREEN:  l = is_ns ? L_GRN : L_RED;
            S_NS_YELLOW: l = is_ns ? L_YEL : L_RED;
            S_EW_GREEN:  l = is_ns ? L_RED : L_GRN;
            S_EW_YELLOW: l = is_ns ? L_RED : L_YEL;
            default:     l = L_RED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tlc_req_encoder.sv
// Merges an arrival pulse and a departure request for one approach into a
// single counter command; simultaneous arrival and departure cancel out.
module tlc_req_encoder
    import tlc_pkg::*;
(
    input  logic       arrive,
    input  logic       depart,
    output logic       en,
    output logic [1:0] w
);

    always_comb begin
        en = 1'b0;
        w  = W_HOLD;
        if (arrive && !depart) begin
            en = 1'b1;
            w  = W_UP;
        end else if (depart && !arrive) begin
            en = 1'b1;
            w  = W_DOWN;
        end
    end

endmodule

// File: rtl/tlc_phase_sequencer.sv
// Two-approach (NS/EW) phase sequencer: times green/yellow/all-red phases from
// the queue counts and issues registered en/w commands to the queue counters.
module tlc_phase_sequencer
    import tlc_pkg::*;
#(
    parameter int MIN_GREEN  = 8,
    parameter int MAX_GREEN  = 32,
    parameter int YELLOW_CYC = 4,
    parameter int ALLRED_CYC = 2,
    parameter int DEPART_CYC = 2,
    parameter int CW         = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] ns_count,
    input  logic [CW-1:0] ew_count,
    input  logic          ns_arrive,
    input  logic          ew_arrive,
    output logic          ns_en,
    output logic [1:0]    ns_w,
    output logic          ew_en,
    output logic [1:0]    ew_w,
    output logic [2:0]    ns_light,
    output logic [2:0]    ew_light
);

    localparam int T_LONG = (MAX_GREEN > YELLOW_CYC) ?
                            ((MAX_GREEN > ALLRED_CYC) ? MAX_GREEN : ALLRED_CYC) :
                            ((YELLOW_CYC > ALLRED_CYC) ? YELLOW_CYC : ALLRED_CYC);
    localparam int TW = (T_LONG > 2) ? $clog2(T_LONG) : 1;
    localparam int DW = (DEPART_CYC > 2) ? $clog2(DEPART_CYC) : 1;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [DW-1:0] dep_q, dep_d;

    logic          in_green;
    logic [CW-1:0] own_count, opp_count;
    logic          dep_wrap, green_exit, timer_sat;
    logic          ns_depart, ew_depart;
    logic          ns_en_c, ew_en_c;
    logic [1:0]    ns_w_c, ew_w_c;

    always_comb begin
        in_green   = (state_q == S_NS_GREEN) || (state_q == S_EW_GREEN);
        own_count  = (state_q == S_NS_GREEN) ? ns_count : ew_count;
        opp_count  = (state_q == S_NS_GREEN) ? ew_count : ns_count;
        timer_sat  = (timer_q == TW'(MAX_GREEN - 1));
        dep_wrap   = in_green && (dep_q == DW'(DEPART_CYC - 1));
        // Green only yields when someone is waiting on the other approach.
        green_exit = (opp_count != '0) &&
                     (timer_sat || ((timer_q >= TW'(MIN_GREEN - 1)) && (own_count == '0)));
        ns_depart  = dep_wrap && (state_q == S_NS_GREEN) && (ns_count != '0);
        ew_depart  = dep_wrap && (state_q == S_EW_GREEN) && (ew_count != '0);
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TW'(1);
        dep_d   = '0;
        case (state_q)
            S_RED_TO_NS: begin
                if (timer_q == TW'(ALLRED_CYC - 1)) begin
                    state_d = S_NS_GREEN;
                    timer_d = '0;
                end
            end
            S_NS_GREEN, S_EW_GREEN: begin
                dep_d = dep_wrap ? '0 : dep_q + DW'(1);
                if (green_exit) begin
                    state_d = (state_q == S_NS_GREEN) ? S_NS_YELLOW : S_EW_YELLOW;
                    timer_d = '0;
                    dep_d   = '0;
                end else if (timer_sat) begin
                    timer_d = timer_q;
                end
            end
            S_NS_YELLOW: begin
                if (timer_q == TW'(YELLOW_CYC - 1)) begin
                    state_d = S_RED_TO_EW;
                    timer_d = '0;
                end
            end
            S_RED_TO_EW: begin
                if (timer_q == TW'(ALLRED_CYC - 1)) begin
                    state_d = S_EW_GREEN;
                    timer_d = '0;
                end
            end
            S_EW_YELLOW: begin
                if (timer_q == TW'(YELLOW_CYC - 1)) begin
                    state_d = S_RED_TO_NS;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = S_RED_TO_NS;
                timer_d = '0;
            end
        endcase
    end

    tlc_req_encoder u_ns_enc (
        .arrive (ns_arrive),
        .depart (ns_depart),
        .en     (ns_en_c),
        .w      (ns_w_c)
    );

    tlc_req_encoder u_ew_enc (
        .arrive (ew_arrive),
        .depart (ew_depart),
        .en     (ew_en_c),
        .w      (ew_w_c)
    );

    // Lights are registered from the next state so they always match state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_RED_TO_NS;
            timer_q  <= '0;
            dep_q    <= '0;
            ns_light <= L_RED;
            ew_light <= L_RED;
            ns_en    <= 1'b0;
            ns_w     <= W_HOLD;
            ew_en    <= 1'b0;
            ew_w     <= W_HOLD;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            dep_q    <= dep_d;
            ns_light <= light_of(state_d, 1'b1);
            ew_light <= light_of(state_d, 1'b0);
            ns_en    <= ns_en_c;
            ns_w     <= ns_w_c;
            ew_en    <= ew_en_c;
            ew_w     <= ew_w_c;
        end
    end

endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// Bench for tlc_phase_sequencer: drives queue counts (forced or from a modelled
// counter) and arrivals, comparing every cycle against a phase-table model.
module tb_tlc_phase_sequencer;

    localparam int MIN_G    = 8;
    localparam int MAX_G    = 32;
    localparam int YEL_C    = 4;
    localparam int ALLRED_C = 2;
    localparam int DEP_C    = 2;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    logic       clk, rst;
    logic [3:0] ns_count, ew_count;
    logic       ns_arrive, ew_arrive;
    logic       ns_en, ew_en;
    logic [1:0] ns_w, ew_w;
    logic [2:0] ns_light, ew_light;

    int errors = 0;
    int checks = 0;
    bit ext_mode = 0;

    // Phase 0..5: red->NS, NS green, NS yellow, red->EW, EW green, EW yellow.
    int         m_phase, m_t;
    logic [2:0] m_nl, m_el;
    logic [2:0] m_ncmd, m_ecmd;
    logic [2:0] ns_tab [6];
    logic [2:0] ew_tab [6];

    tlc_phase_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .ns_count  (ns_count),
        .ew_count  (ew_count),
        .ns_arrive (ns_arrive),
        .ew_arrive (ew_arrive),
        .ns_en     (ns_en),
        .ns_w      (ns_w),
        .ew_en     (ew_en),
        .ew_w      (ew_w),
        .ns_light  (ns_light),
        .ew_light  (ew_light)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] cmd(input bit arr, input bit dep);
        if (arr && !dep) return 3'b1_01;
        if (dep && !arr) return 3'b1_10;
        return 3'b0_00;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_t     = 0;
        m_nl    = RED;
        m_el    = RED;
        m_ncmd  = 3'b000;
        m_ecmd  = 3'b000;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        ns_arrive = 1'b0;
        ew_arrive = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock: advance the model from pre-edge inputs, then clock the DUT
    // and let the external queue counter apply the command it saw.
    task automatic step(input logic a_ns, input logic a_ew);
        int   own, opp;
        bit   ex, dep_ns, dep_ew;
        logic pe_ns, pe_ew;
        logic [1:0] pw_ns, pw_ew;
        ns_arrive = a_ns;
        ew_arrive = a_ew;
        own = (m_phase == 1) ? int'(ns_count) : int'(ew_count);
        opp = (m_phase == 1) ? int'(ew_count) : int'(ns_count);
        dep_ns = (m_phase == 1) && (ns_count != 0) && ((m_t % DEP_C) == DEP_C - 1);
        dep_ew = (m_phase == 4) && (ew_count != 0) && ((m_t % DEP_C) == DEP_C - 1);
        if (m_phase == 1 || m_phase == 4)
            ex = (opp != 0) && ((m_t >= MAX_G - 1) || ((m_t >= MIN_G - 1) && own == 0));
        else if (m_phase == 0 || m_phase == 3)
            ex = (m_t == ALLRED_C - 1);
        else
            ex = (m_t == YEL_C - 1);
        if (ex) begin
            m_phase = (m_phase + 1) % 6;
            m_t = 0;
        end else begin
            m_t++;
        end
        m_nl   = ns_tab[m_phase];
        m_el   = ew_tab[m_phase];
        m_ncmd = cmd(a_ns, dep_ns);
        m_ecmd = cmd(a_ew, dep_ew);
        pe_ns = ns_en; pw_ns = ns_w;
        pe_ew = ew_en; pw_ew = ew_w;
        @(posedge clk);
        #1;
        if (ext_mode) begin
            if (pe_ns && pw_ns == 2'b01 && ns_count != 4'hF) ns_count = ns_count + 1'b1;
            else if (pe_ns && pw_ns == 2'b10 && ns_count != 4'h0) ns_count = ns_count - 1'b1;
            if (pe_ew && pw_ew == 2'b01 && ew_count != 4'hF) ew_count = ew_count + 1'b1;
            else if (pe_ew && pw_ew == 2'b10 && ew_count != 4'h0) ew_count = ew_count - 1'b1;
        end
        ns_arrive = 1'b0;
        ew_arrive = 1'b0;
    endtask

    task automatic test_reset();
        ext_mode = 0;
        ns_count = 4'd5;
        ew_count = 4'd0;
        apply_reset();
        checks++;
        if ({ns_light, ew_light, ns_en, ns_w, ew_en, ew_w} !== {RED, RED, 6'b0})
            begin errors++; $display("FAIL reset_values: got %h want %h",
                {ns_light, ew_light, ns_en, ns_w, ew_en, ew_w}, {RED, RED, 6'b0}); end
        for (int i = 0; i < 5; i++) step(i == 4, 1'b0);
        checks++;
        if (ns_light !== GRN) begin errors++; $display("FAIL pre_reset_green: got %b want %b", ns_light, GRN); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ns_light, ew_light, ns_en, ns_w, ew_en, ew_w} !== {RED, RED, 6'b0})
            begin errors++; $display("FAIL async_reset: got %h want %h",
                {ns_light, ew_light, ns_en, ns_w, ew_en, ew_w}, {RED, RED, 6'b0}); end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            step(1'b0, 1'b0);
            checks++;
            if (ns_light !== ((k == 2) ? GRN : RED))
                begin errors++; $display("FAIL release_ns_light k=%0d: got %b want %b", k, ns_light, (k == 2) ? GRN : RED); end
            checks++;
            if ({ns_light, ew_light, ns_en, ns_w, ew_en, ew_w} !== {m_nl, m_el, m_ncmd, m_ecmd})
                begin errors++; $display("FAIL release_outputs k=%0d: got %h want %h", k,
                    {ns_light, ew_light, ns_en, ns_w, ew_en, ew_w}, {m_nl, m_el, m_ncmd, m_ecmd}); end
        end
    endtask

    task automatic test_idle_hold();
        ext_mode = 0;
        ns_count = 4'd0;
        ew_count = 4'd0;
        apply_reset();
        for (int k = 1; k <= 80; k++) begin
            step(1'b0, 1'b0);
            checks++;
            if (ns_en !== 1'b0) begin errors++; $display("FAIL idle_ns_en k=%0d: got %b want 0", k, ns_en); end
            checks++;
            if ({ns_light, ew_light, ns_en, ns_w, ew_en, ew_w} !== {m_nl, m_el, m_ncmd, m_ecmd})
                begin errors++; $display("FAIL idle_outputs k=%0d: got %h want %h", k,
                    {ns_light, ew_light, ns_en, ns_w, ew_en, ew_w}, {m_nl, m_el, m_ncmd, m_ecmd}); end
        end
        checks++;
        if (ns_light !== GRN) begin errors++; $display("FAIL idle_green_held: got %b want %b", ns_light, GRN); end
    endtask

    task automatic test_gap_out();
        logic [2:0] ns_exp, ew_exp;
        bit         en_exp;
        ext_mode = 1;
        ns_count = 4'd3;
        ew_count = 4'd1;
        apply_reset();
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 1'b0);
            ns_exp = (k < 2) ? RED : (k < 10) ? GRN : (k < 14) ? YEL : RED;
            ew_exp = (k < 16) ? RED : GRN;
            en_exp = (k == 4) || (k == 6) || (k == 8);
            checks++;
            if ({ns_light, ew_light} !== {ns_exp, ew_exp})
                begin errors++; $display("FAIL gap_lights k=%0d: got %b/%b want %b/%b", k, ns_light, ew_light, ns_exp, ew_exp); end
            checks++;
            if ({ns_en, ns_w} !== (en_exp ? 3'b1_10 : 3'b0_00))
                begin errors++; $display("FAIL gap_depart k=%0d: got %b%b want en=%b", k, ns_en, ns_w, en_exp); end
            checks++;
            if ({ns_light, ew_light, ns_en, ns_w, ew_en, ew_w} !== {m_nl, m_el, m_ncmd, m_ecmd})
                begin errors++; $display("FAIL gap_outputs k=%0d: got %h want %h", k,
                    {ns_light, ew_light, ns_en, ns_w, ew_en, ew_w}, {m_nl, m_el, m_ncmd, m_ecmd}); end
        end
        checks++;
        if (ns_count !== 4'd0) begin errors++; $display("FAIL gap_queue_drained: got %0d want 0", ns_count); end
    endtask

    task automatic test_max_green();
        int green_n;
        ext_mode = 0;
        ns_count = 4'd15;
        ew_count = 4'd2;
        green_n = 0;
        apply_reset();
        for (int k = 1; k <= 36; k++) begin
            step(1'b0, 1'b0);
            if (ns_light === GRN) green_n++;
            if (k == 34) begin
                checks++;
                if (ns_light !== YEL) begin errors++; $display("FAIL max_yellow_entry: got %b want %b", ns_light, YEL); end
            end
            checks++;
            if ({ns_light, ew_light, ns_en, ns_w, ew_en, ew_w} !== {m_nl, m_el, m_ncmd, m_ecmd})
                begin errors++; $display("FAIL max_outputs k=%0d: got %h want %h", k,
                    {ns_light, ew_light, ns_en, ns_w, ew_en, ew_w}, {m_nl, m_el, m_ncmd, m_ecmd}); end
        end
        checks++;
        if (green_n != MAX_G) begin errors++; $display("FAIL max_green_len: got %0d want %0d", green_n, MAX_G); end
    endtask

    task automatic test_collision();
        ext_mode = 0;
        ns_count = 4'd5;
        ew_count = 4'd0;
        apply_reset();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        checks++;
        if ({ns_en, ns_w} !== 3'b0_00) begin errors++; $display("FAIL collide_cancel: got %b%b want 000", ns_en, ns_w); end
        step(1'b1, 1'b0);
        checks++;
        if ({ns_en, ns_w} !== 3'b1_01) begin errors++; $display("FAIL collide_arrive_only: got %b%b want 101", ns_en, ns_w); end
        step(1'b0, 1'b0);
        checks++;
        if ({ns_en, ns_w} !== 3'b1_10) begin errors++; $display("FAIL collide_depart_only: got %b%b want 110", ns_en, ns_w); end
        checks++;
        if ({ns_light, ew_light, ns_en, ns_w, ew_en, ew_w} !== {m_nl, m_el, m_ncmd, m_ecmd})
            begin errors++; $display("FAIL collide_outputs: got %h want %h",
                {ns_light, ew_light, ns_en, ns_w, ew_en, ew_w}, {m_nl, m_el, m_ncmd, m_ecmd}); end
    endtask

    task automatic test_ew_arrive();
        bit a;
        ext_mode = 0;
        ns_count = 4'd5;
        ew_count = 4'd0;
        for (int k = 1; k <= 30; k++) begin
            a = ($urandom_range(0, 1) == 1);
            step(1'b0, a);
            checks++;
            if ({ew_en, ew_w, ew_light} !== {a, a ? 2'b01 : 2'b00, RED})
                begin errors++; $display("FAIL ew_arrive k=%0d: got en=%b w=%b l=%b want en=%b", k, ew_en, ew_w, ew_light, a); end
            checks++;
            if ({ns_light, ew_light, ns_en, ns_w, ew_en, ew_w} !== {m_nl, m_el, m_ncmd, m_ecmd})
                begin errors++; $display("FAIL ew_outputs k=%0d: got %h want %h", k,
                    {ns_light, ew_light, ns_en, ns_w, ew_en, ew_w}, {m_nl, m_el, m_ncmd, m_ecmd}); end
        end
    endtask

    task automatic test_random();
        ext_mode = 1;
        ns_count = 4'($urandom_range(0, 15));
        ew_count = 4'($urandom_range(0, 15));
        apply_reset();
        for (int k = 1; k <= 3000; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                #1;
                checks++;
                if ({ns_light, ew_light, ns_en, ns_w, ew_en, ew_w} !== {RED, RED, 6'b0})
                    begin errors++; $display("FAIL rand_reset k=%0d: got %h", k,
                        {ns_light, ew_light, ns_en, ns_w, ew_en, ew_w}); end
                model_reset();
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
            checks++;
            if ({ns_light, ew_light, ns_en, ns_w, ew_en, ew_w} !== {m_nl, m_el, m_ncmd, m_ecmd})
                begin errors++; $display("FAIL rand_outputs k=%0d: got %h want %h", k,
                    {ns_light, ew_light, ns_en, ns_w, ew_en, ew_w}, {m_nl, m_el, m_ncmd, m_ecmd}); end
            checks++;
            if ((ns_en && ns_w == 2'b10 && ns_count == 0) || (ew_en && ew_w == 2'b10 && ew_count == 0))
                begin errors++; $display("FAIL rand_dec_at_zero k=%0d: ns=%0d ew=%0d", k, ns_count, ew_count); end
        end
    endtask

    initial begin
        ns_tab = '{RED, GRN, YEL, RED, RED, RED};
        ew_tab = '{RED, RED, RED, RED, GRN, YEL};
        rst = 1'b1;
        ns_count = 4'd0;
        ew_count = 4'd0;
        ns_arrive = 1'b0;
        ew_arrive = 1'b0;
        model_reset();
        test_reset();
        test_idle_hold();
        test_gap_out();
        test_max_green();
        test_collision();
        test_ew_arrive();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
